// File: rtl/bitmanip_unit.sv
`default_nettype none
// ============================================================================
// Module      : bitmanip_unit
// Description : Bit-manipulation execution unit. Logic, bytewise and count
//               ops complete one cycle after acceptance; carry-less
//               multiplies iterate CLMUL_STEP rs2 bits per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bitmanip_unit #(
  parameter int XLEN       = 32,
  parameter int CLMUL_STEP = 4,
  parameter int TAG_W      = 6
) (
  input  logic             cpu_clock_i,
  input  logic             cpu_reset_n_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [XLEN-1:0]  c_o,
  output logic [TAG_W-1:0] tag_o
);

  // Number of clmul processing steps and the counter that walks them.
  localparam int              K        = XLEN / CLMUL_STEP;
  localparam int              CNT_W    = $clog2(K) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Width of a bit count (0..XLEN inclusive).
  localparam int              CW       = $clog2(XLEN) + 1;
  localparam int              NBYTES   = XLEN / 8;

  // Operation encoding.
  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_ORCB   = 4'b0011;
  localparam logic [3:0] OP_ANDN   = 4'b0100;
  localparam logic [3:0] OP_ORN    = 4'b0101;
  localparam logic [3:0] OP_XNOR   = 4'b0110;
  localparam logic [3:0] OP_CTZ    = 4'b1000;
  localparam logic [3:0] OP_REV8   = 4'b1010;
  localparam logic [3:0] OP_CPOP   = 4'b1011;
  localparam logic [3:0] OP_CLZ    = 4'b1100;
  localparam logic [3:0] OP_CLMUL  = 4'b1101;
  localparam logic [3:0] OP_CLMULH = 4'b1110;
  localparam logic [3:0] OP_CLMULR = 4'b1111;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLMUL = 1'b1
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [2*XLEN-1:0]   a_sh_q;   // rs1 pre-shifted to the current bit index
  logic [XLEN-1:0]     b_sh_q;   // rs2 with already-consumed bits shifted out
  logic [3:0]          op_q;
  logic [TAG_W-1:0]    tag_q;
  logic                valid_q;
  logic [XLEN-1:0]     c_q;
  logic [TAG_W-1:0]    tag_out_q;

  logic [XLEN-1:0]     orcb_res;
  logic [XLEN-1:0]     rev8_res;
  logic [XLEN-1:0]     single_d;
  logic [2*XLEN-1:0]   acc_first_d;
  logic [2*XLEN-1:0]   acc_step_d;
  logic [XLEN-1:0]     clmul_res_d;
  logic                is_clmul_op;

  // One clmul step: xor shifted copies of a into acc for each set bit.
  function automatic logic [2*XLEN-1:0] clmul_step(
    input logic [2*XLEN-1:0]   acc,
    input logic [2*XLEN-1:0]   a_sh,
    input logic [CLMUL_STEP-1:0] bits
  );
    logic [2*XLEN-1:0] r;
    r = acc;
    for (int j = 0; j < CLMUL_STEP; j++) begin
      if (bits[j]) r = r ^ (a_sh << j);
    end
    return r;
  endfunction

  // Trailing zeros; scanning downward leaves the lowest set bit's index.
  function automatic logic [CW-1:0] count_tz(input logic [XLEN-1:0] v);
    logic [CW-1:0] n;
    n = CW'(XLEN);
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (v[i]) n = CW'(i);
    end
    return n;
  endfunction

  // Leading zeros; scanning upward leaves the highest set bit's distance.
  function automatic logic [CW-1:0] count_lz(input logic [XLEN-1:0] v);
    logic [CW-1:0] n;
    n = CW'(XLEN);
    for (int i = 0; i < XLEN; i++) begin
      if (v[i]) n = CW'(XLEN - 1 - i);
    end
    return n;
  endfunction

  // Population count.
  function automatic logic [CW-1:0] count_pop(input logic [XLEN-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < XLEN; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  // Per-byte OR-combine and byte reversal are pure wiring.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
    assign orcb_res[8*gi +: 8] = {8{|a_i[8*gi +: 8]}};
    assign rev8_res[8*gi +: 8] = a_i[8*(NBYTES-1-gi) +: 8];
  end

  assign is_clmul_op = (op_i == OP_CLMUL) || (op_i == OP_CLMULH) ||
                       (op_i == OP_CLMULR);

  // Single-cycle result selection; undefined codes yield zero.
  always_comb begin
    single_d = '0;
    case (op_i)
      OP_AND:  single_d = a_i & b_i;
      OP_OR:   single_d = a_i | b_i;
      OP_XOR:  single_d = a_i ^ b_i;
      OP_ANDN: single_d = a_i & ~b_i;
      OP_ORN:  single_d = a_i | ~b_i;
      OP_XNOR: single_d = ~(a_i ^ b_i);
      OP_ORCB: single_d = orcb_res;
      OP_REV8: single_d = rev8_res;
      OP_CTZ:  single_d = XLEN'(count_tz(a_i));
      OP_CLZ:  single_d = XLEN'(count_lz(a_i));
      OP_CPOP: single_d = XLEN'(count_pop(a_i));
      default: single_d = '0;
    endcase
  end

  // Clmul accumulator next values and final result slice of the product.
  always_comb begin
    acc_first_d = clmul_step('0, {{XLEN{1'b0}}, a_i}, b_i[CLMUL_STEP-1:0]);
    acc_step_d  = clmul_step(acc_q, a_sh_q, b_sh_q[CLMUL_STEP-1:0]);
    clmul_res_d = acc_step_d[XLEN-1:0];
    case (op_q)
      OP_CLMULH: clmul_res_d = acc_step_d[2*XLEN-1:XLEN];
      OP_CLMULR: clmul_res_d = acc_step_d[2*XLEN-2:XLEN-1];
      default:   clmul_res_d = acc_step_d[XLEN-1:0];
    endcase
  end

  // Control FSM with registered outputs. The first clmul step is folded
  // into the accepting edge, so K steps finish K-1 edges after acceptance.
  always_ff @(posedge cpu_clock_i) begin
    if (!cpu_reset_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      valid_q   <= 1'b0;
      c_q       <= '0;
      tag_out_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (flush_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        acc_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (valid_i) begin
              if (is_clmul_op) begin
                acc_q   <= acc_first_d;
                a_sh_q  <= {{XLEN{1'b0}}, a_i} << CLMUL_STEP;
                b_sh_q  <= b_i >> CLMUL_STEP;
                op_q    <= op_i;
                tag_q   <= tag_i;
                cnt_q   <= CNT_ONE;
                state_q <= CLMUL;
              end else begin
                valid_q   <= 1'b1;
                c_q       <= single_d;
                tag_out_q <= tag_i;
              end
            end
          end
          CLMUL: begin
            if (cnt_q == LAST_CNT) begin
              valid_q   <= 1'b1;
              c_q       <= clmul_res_d;
              tag_out_q <= tag_q;
              acc_q     <= '0;
              cnt_q     <= '0;
              state_q   <= IDLE;
            end else begin
              acc_q  <= acc_step_d;
              a_sh_q <= a_sh_q << CLMUL_STEP;
              b_sh_q <= b_sh_q >> CLMUL_STEP;
              cnt_q  <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
          end
        endcase
      end
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = valid_q;
  assign c_o     = c_q;
  assign tag_o   = tag_out_q;

endmodule
`default_nettype wire

// File: tb/tb_bitmanip_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitmanip_unit
// Description : Directed self-checking bench for bitmanip_unit (32-bit/4-step
//               and 64-bit/8-step instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitmanip_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;

  logic        valid32, ready32, vout32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, c32;
  logic [5:0]  tag32, tago32;

  logic        valid64, ready64, vout64;
  logic [3:0]  op64;
  logic [63:0] a64, b64, c64;
  logic [5:0]  tag64, tago64;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int pulses;

  bitmanip_unit #(.XLEN(32), .CLMUL_STEP(4), .TAG_W(6)) dut32 (
    .cpu_clock_i(clk), .cpu_reset_n_i(rst_n), .flush_i(flush),
    .valid_i(valid32), .ready_o(ready32), .op_i(op32), .a_i(a32), .b_i(b32),
    .tag_i(tag32), .valid_o(vout32), .c_o(c32), .tag_o(tago32)
  );

  bitmanip_unit #(.XLEN(64), .CLMUL_STEP(8), .TAG_W(6)) dut64 (
    .cpu_clock_i(clk), .cpu_reset_n_i(rst_n), .flush_i(flush),
    .valid_i(valid64), .ready_o(ready64), .op_i(op64), .a_i(a64), .b_i(b64),
    .tag_i(tag64), .valid_o(vout64), .c_o(c64), .tag_o(tago64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic drive32(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] tag);
    valid32 = 1'b1;
    op32    = op;
    a32     = a;
    b32     = b;
    tag32   = tag;
  endtask

  // Issue a 32-bit op, wait (bounded) for its result, check latency/result.
  task automatic run32(input string name, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag, input logic [31:0] exp_c,
                       input int exp_lat);
    drive32(op, a, b, tag);
    step();
    valid32 = 1'b0;
    lat = 1;
    while (!vout32 && lat < 20) begin
      step();
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_c"},   64'(c32), 64'(exp_c));
    check({name, "_tag"}, 64'(tago32), 64'(tag));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    valid32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; tag32 = '0;
    valid64 = 1'b0; op64 = '0; a64 = '0; b64 = '0; tag64 = '0;

    // Reset state
    step(); step();
    check("rst_valid", 64'(vout32), 64'd0);
    check("rst_c",     64'(c32),    64'd0);
    check("rst_tag",   64'(tago32), 64'd0);
    rst_n = 1'b1;
    step();
    check("rst_ready", 64'(ready32), 64'd1);
    check("rst_ready64", 64'(ready64), 64'd1);

    // Counts, including the all-zero boundary
    run32("clz_8000",  4'b1100, 32'h0000_8000, 32'h0, 6'd1, 32'd16, 1);
    run32("ctz_0",     4'b1000, 32'h0,         32'h0, 6'd2, 32'd32, 1);
    run32("cpop",      4'b1011, 32'hF0F0_0001, 32'h0, 6'd3, 32'd9,  1);
    run32("ctz_40",    4'b1000, 32'h0000_0040, 32'h0, 6'd4, 32'd6,  1);
    run32("undef_7",   4'b0111, 32'hFFFF_FFFF, 32'h1, 6'd6, 32'd0,  1);
    run32("undef_9",   4'b1001, 32'hFFFF_FFFF, 32'h1, 6'd7, 32'd0,  1);
    run32("orn",       4'b0101, 32'h0000_00F0, 32'hFFFF_FF0F, 6'd8, 32'h0000_00F0, 1);
    run32("xnor",      4'b0110, 32'hFFFF_0000, 32'hFF00_FF00, 6'd9, 32'hFF00_00FF, 1);

    // Clmul: ready low for 7 cycles; a held request is ignored meanwhile
    drive32(4'b1101, 32'd3, 32'd3, 6'd5);
    step();
    drive32(4'b0010, 32'hFF, 32'h0F, 6'd9);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      if (ready32 !== 1'b0 || vout32 !== 1'b0) pulses++;
      step();
    end
    check("clmul_busy_cycles", 64'(pulses), 64'd0);
    check("clmul_valid", 64'(vout32), 64'd1);
    check("clmul_c",     64'(c32),    64'd5);
    check("clmul_tag",   64'(tago32), 64'd5);
    check("clmul_ready", 64'(ready32), 64'd1);
    step();
    valid32 = 1'b0;
    check("held_xor_c",   64'(c32),    64'hF0);
    check("held_xor_tag", 64'(tago32), 64'd9);
    check("held_xor_v",   64'(vout32), 64'd1);

    run32("clmulh", 4'b1110, 32'h8000_0000, 32'h8000_0000, 6'd10, 32'h4000_0000, 8);
    run32("clmulr", 4'b1111, 32'h8000_0000, 32'h8000_0000, 6'd11, 32'h8000_0000, 8);
    run32("clmul_x", 4'b1101, 32'h0000_0005, 32'h0000_0007, 6'd12, 32'h0000_001B, 8);

    // Back-to-back single-cycle ops
    drive32(4'b0010, 32'hFF, 32'h0F, 6'd1);
    step();
    check("b2b_xor", 64'(c32), 64'hF0);
    drive32(4'b1010, 32'h1122_3344, 32'h0, 6'd2);
    step();
    check("b2b_rev8", 64'(c32), 64'h4433_2211);
    check("b2b_rev8_v", 64'(vout32), 64'd1);
    drive32(4'b0011, 32'h0100_0000, 32'h0, 6'd3);
    step();
    valid32 = 1'b0;
    check("b2b_orcb", 64'(c32), 64'hFF00_0000);
    check("b2b_orcb_tag", 64'(tago32), 64'd3);
    step();
    check("idle_valid", 64'(vout32), 64'd0);

    // Flush three cycles into a clmul
    drive32(4'b1101, 32'd3, 32'd3, 6'd5);
    step();
    valid32 = 1'b0;
    step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", 64'(vout32), 64'd0);
    check("flush_ready", 64'(ready32), 64'd1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (vout32 === 1'b1) pulses++;
      step();
    end
    check("flush_no_pulse", 64'(pulses), 64'd0);
    run32("andn", 4'b0100, 32'hFF, 32'h0F, 6'd13, 32'hF0, 1);

    // Reset at cycle 4 of a clmul; reset beats valid_i and flush_i
    drive32(4'b1101, 32'd3, 32'd3, 6'd5);
    step();
    valid32 = 1'b0;
    step(); step();
    rst_n = 1'b0;
    drive32(4'b1100, 32'h1, 32'h0, 6'd20);
    flush = 1'b1;
    step();
    check("mid_rst_valid", 64'(vout32), 64'd0);
    check("mid_rst_c",     64'(c32),    64'd0);
    check("mid_rst_tag",   64'(tago32), 64'd0);
    step();
    valid32 = 1'b0;
    flush = 1'b0;
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 64'(ready32), 64'd1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (vout32 === 1'b1) pulses++;
      step();
    end
    check("post_rst_no_pulse", 64'(pulses), 64'd0);
    run32("clz_1", 4'b1100, 32'h1, 32'h0, 6'd21, 32'd31, 1);

    // 64-bit, 8-step instance
    valid64 = 1'b1; op64 = 4'b1101; a64 = 64'hFFFF_FFFF_FFFF_FFFF;
    b64 = 64'd1; tag64 = 6'd33;
    step();
    valid64 = 1'b0;
    lat = 1;
    while (!vout64 && lat < 20) begin
      step();
      lat++;
    end
    check("c64_lat", 64'(lat), 64'd8);
    check("c64_c",   c64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("c64_tag", 64'(tago64), 64'd33);
    valid64 = 1'b1; op64 = 4'b1100; a64 = 64'd0; tag64 = 6'd34;
    step();
    valid64 = 1'b0;
    check("clz64_0", c64, 64'd64);
    check("clz64_v", 64'(vout64), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bitmanip_unit.md
BITMANIP_UNIT -- requirements
Module: bitmanip_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter CLMUL_STEP, default 4, rs2 bits consumed per carry-less-multiply cycle; legal values 1, 2, 4 or 8, and it SHALL divide XLEN.
REQ-003 SHALL have parameter TAG_W, default 6, width of the result tag.
REQ-004 cpu_clock_i  in  1  single clock; all state updates on its rising edge.
REQ-005 cpu_reset_n_i  in  1  synchronous, active-low reset.
REQ-006 flush_i  in  1  discards any in-flight operation.
REQ-007 valid_i  in  1  operation request.
REQ-008 ready_o  out  1  unit can accept a request this cycle.
REQ-009 op_i  in  4  operation code.
REQ-010 a_i  in  XLEN  rs1.
REQ-011 b_i  in  XLEN  rs2 or immediate.
REQ-012 tag_i  in  TAG_W  destination tag.
REQ-013 valid_o  out  1  result valid, single-cycle pulse; no back-pressure.
REQ-014 c_o  out  XLEN  result.
REQ-015 tag_o  out  TAG_W  tag of the request producing c_o.

Function
REQ-016 The op_i encoding SHALL be as follows.
- Logic, XLEN-wide: 0000 and, 0001 or, 0010 xor, 0100 andn, 0101 orn, 0110 xnor.
- Bytewise: 0011 orc.b (per byte), 1010 rev8 (XLEN/8 bytes reversed).
- Counts: 1000 ctz, 1100 clz, 1011 cpop.
- Carry-less multiply: 1101 clmul, 1110 clmulh, 1111 clmulr.
- 0111 and 1001 are undefined; they SHALL return c_o=0 with normal single-cycle timing.
REQ-017 A request SHALL be accepted on any edge where valid_i & ready_o & ~flush_i.
REQ-018 ctz and clz SHALL return XLEN when a_i is 0; count results SHALL be zero-extended to XLEN.
REQ-019 The FSM SHALL have states IDLE and CLMUL; ready_o SHALL be 1 only in IDLE.
REQ-020 A single-cycle op accepted at edge N SHALL give valid_o=1, c_o and tag_o at cycle N+1; the FSM SHALL stay in IDLE, so back-to-back ops give one result per cycle.
REQ-021 A clmul-class op accepted at edge N SHALL behave as follows.
- It SHALL latch a_i, b_i, op and tag, and enter CLMUL.
- Each cycle it SHALL process CLMUL_STEP bits of b, LSB first, into a 2*XLEN accumulator: acc ^= (a << bit index) for each set bit.
- After K=XLEN/CLMUL_STEP processing cycles it SHALL pulse valid_o at cycle N+K and return to IDLE at that edge.
- ready_o SHALL be 1 again in the valid_o cycle.
REQ-022 With p the 2*XLEN product, the clmul-class results SHALL be: clmul = p[XLEN-1:0], clmulh = p[2XLEN-1:XLEN], clmulr = p[2XLEN-2:XLEN-1].
REQ-023 The iteration counter SHALL be log2(K)+1 bits wide and SHALL wrap to 0 on completion.
REQ-024 A new request presented while the FSM is in CLMUL SHALL be ignored (ready_o=0); the requester holds it.
REQ-025 flush_i asserted in any cycle SHALL have the following effect.
- It SHALL force the FSM to IDLE at that edge.
- valid_o SHALL be 0 the following cycle.
- Any accumulated state SHALL be discarded.
- It SHALL take priority over acceptance and over completion on the same edge.
REQ-026 valid_o SHALL be 0 whenever no result completes; c_o and tag_o values are don't-care while valid_o=0.

Reset
REQ-027 With cpu_reset_n_i=0 at an edge: FSM SHALL go to IDLE, valid_o=0, c_o=0, tag_o=0, counter=0, accumulator=0; ready_o SHALL be 1 from the first cycle after reset deasserts.
REQ-028 Reset mid-CLMUL SHALL abandon the operation with no valid_o pulse, and reset SHALL take priority over flush_i and valid_i.

Verification
REQ-029 XLEN=32: op=1100, a=0x0000_8000 -> next cycle valid_o=1, c_o=16; op=1000, a=0 -> c_o=32; op=1011, a=0xF0F0_0001 -> c_o=9.
REQ-030 XLEN=32, STEP=4: op=1101, a=3, b=3, tag=5 -> ready_o=0 for 7 cycles, valid_o at N+8 with c_o=5, tag_o=5; op=1110, a=b=0x8000_0000 -> c_o=0x4000_0000; op=1111 with same operands -> c_o=0x8000_0000.
REQ-031 Back-to-back: xor(0xFF,0x0F), rev8(0x1122_3344), orc.b(0x0100_0000) on 3 consecutive cycles -> c_o = 0xF0, then 0x4433_2211, then 0xFF00_0000 on 3 consecutive cycles.
REQ-032 flush_i asserted 3 cycles into a clmul -> no valid_o pulse, ready_o=1 next cycle; a following andn(0xFF,0x0F) -> c_o=0xF0.
REQ-033 cpu_reset_n_i=0 at cycle 4 of a clmul -> valid_o stays 0 and all outputs are 0; after release, clz(0x1) -> c_o=31.
REQ-034 XLEN=64, STEP=8: clmul a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> valid_o at N+8, c_o equals a; clz(0) -> c_o=64.
